fft8_bfly_scheduler: RTL

Sequencer for the 8-point radix-2 DIT FFT core. It drives the operand-buffer read ports, twiddle selection and write-back for the shared butterfly datapath (one complex multiplier plus add/sub) through 3 stages × 4 butterflies. It inserts drain cycles so that no stage reads data the previous stage has not yet written. The input buffer is already in bit-reversed order, and the datapath is a fixed-latency pipeline.

---
 rtl/fft8_bfly_scheduler_if.sv | 30 +++
 rtl/fft8_bfly_scheduler.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/fft8_bfly_scheduler_if.sv
// Butterfly-scheduler bundle: start/status, operand reads, twiddle and write-back.
interface fft8_bfly_scheduler_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             busy;
  logic             done;
  logic [1:0]       stage;
  logic             rd_en;
  logic [2:0]       rd_addr_a;
  logic [2:0]       rd_addr_b;
  logic [1:0]       tw_idx;
  logic [WIDTH-1:0] tw_real;
  logic [WIDTH-1:0] tw_img;
  logic             wr_en;
  logic [2:0]       wr_addr_a;
  logic [2:0]       wr_addr_b;

  modport master (
    input  start,
    output busy, done, stage, rd_en, rd_addr_a, rd_addr_b,
           tw_idx, tw_real, tw_img, wr_en, wr_addr_a, wr_addr_b
  );

  modport slave (
    output start,
    input  busy, done, stage, rd_en, rd_addr_a, rd_addr_b,
           tw_idx, tw_real, tw_img, wr_en, wr_addr_a, wr_addr_b
  );
endinterface

// File: rtl/fft8_bfly_scheduler.sv
// Issue sequencer for the shared 8-point radix-2 DIT butterfly: 3 stages x 4
// butterflies, with drain gaps so a stage never reads ahead of the write-back.
//
// state | meaning
// IDLE  | waiting for start; stage/bfly parked at 0
// ISSUE | one butterfly read per cycle, bfly 0..3
// DRAIN | PIPE_LAT bubble cycles while the stage's results land
// DONE  | one-cycle completion pulse, then IDLE
module fft8_bfly_scheduler #(
  parameter int WIDTH    = 32,
  parameter int FRAC     = 16,
  parameter int PIPE_LAT = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  fft8_bfly_scheduler_if.master       bus
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  // W8^1 = (c, -c) with c = round(cos(pi/4) * 2^FRAC)
  localparam real    RT2_HALF = 0.70710678118654752;
  localparam longint ONE_L    = longint'(1) << FRAC;
  localparam longint C45_L    = longint'($rtoi(RT2_HALF * real'(ONE_L) + 0.5));
  localparam logic [WIDTH-1:0] TW_ONE  = WIDTH'(ONE_L);
  localparam logic [WIDTH-1:0] TW_NONE = WIDTH'(-ONE_L);
  localparam logic [WIDTH-1:0] TW_C45  = WIDTH'(C45_L);
  localparam logic [WIDTH-1:0] TW_NC45 = WIDTH'(-C45_L);
  localparam logic [2:0]       DRAIN_TC = 3'(PIPE_LAT - 1);

  state_t     state_q, state_d;
  logic [1:0] stage_q, stage_d;
  logic [1:0] bfly_q, bfly_d;
  logic [2:0] cnt_q, cnt_d;

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             rd_en_q, rd_en_d;
  logic [2:0]       addr_a_q, addr_a_d;
  logic [2:0]       addr_b_q, addr_b_d;
  logic [1:0]       tw_idx_q, tw_idx_d;
  logic [WIDTH-1:0] tw_real_q, tw_real_d;
  logic [WIDTH-1:0] tw_img_q, tw_img_d;
  logic [6:0]       wb_pipe_q [PIPE_LAT];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      stage_q   <= '0;
      bfly_q    <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      addr_a_q  <= '0;
      addr_b_q  <= '0;
      tw_idx_q  <= '0;
      tw_real_q <= '0;
      tw_img_q  <= '0;
      for (int i = 0; i < PIPE_LAT; i++) wb_pipe_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      stage_q   <= stage_d;
      bfly_q    <= bfly_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_en_q   <= rd_en_d;
      addr_a_q  <= addr_a_d;
      addr_b_q  <= addr_b_d;
      tw_idx_q  <= tw_idx_d;
      tw_real_q <= tw_real_d;
      tw_img_q  <= tw_img_d;
      wb_pipe_q[0] <= {rd_en_q, addr_a_q, addr_b_q};
      for (int i = 1; i < PIPE_LAT; i++) wb_pipe_q[i] <= wb_pipe_q[i-1];
    end
  end

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    bfly_d  = bfly_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        stage_d = '0;
        bfly_d  = '0;
        if (bus.start) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (bfly_q == 2'd3) begin
          state_d = S_DRAIN;
          bfly_d  = '0;
          cnt_d   = DRAIN_TC;
        end else begin
          bfly_d = bfly_q + 2'd1;
        end
      end
      S_DRAIN: begin
        if (cnt_q == 3'd0) begin
          if (stage_q == 2'd2) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
            stage_d = stage_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        stage_d = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they appear registered in the
  // cycle the state is entered.
  always_comb begin
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
    rd_en_d   = (state_d == S_ISSUE);
    addr_a_d  = '0;
    addr_b_d  = '0;
    tw_idx_d  = '0;
    tw_real_d = '0;
    tw_img_d  = '0;
    if (rd_en_d) begin
      case (stage_d)
        2'd0: begin
          addr_a_d = {bfly_d, 1'b0};
          addr_b_d = {bfly_d, 1'b1};
          tw_idx_d = 2'd0;
        end
        2'd1: begin
          addr_a_d = {bfly_d[1], 1'b0, bfly_d[0]};
          addr_b_d = {bfly_d[1], 1'b1, bfly_d[0]};
          tw_idx_d = {bfly_d[0], 1'b0};
        end
        default: begin
          addr_a_d = {1'b0, bfly_d};
          addr_b_d = {1'b1, bfly_d};
          tw_idx_d = bfly_d;
        end
      endcase
      case (tw_idx_d)
        2'd0: begin tw_real_d = TW_ONE;  tw_img_d = '0;      end
        2'd1: begin tw_real_d = TW_C45;  tw_img_d = TW_NC45; end
        2'd2: begin tw_real_d = '0;      tw_img_d = TW_NONE; end
        default: begin tw_real_d = TW_NC45; tw_img_d = TW_NC45; end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.stage     = stage_q;
  assign bus.rd_en     = rd_en_q;
  assign bus.rd_addr_a = addr_a_q;
  assign bus.rd_addr_b = addr_b_q;
  assign bus.tw_idx    = tw_idx_q;
  assign bus.tw_real   = tw_real_q;
  assign bus.tw_img    = tw_img_q;
  assign bus.wr_en     = wb_pipe_q[PIPE_LAT-1][6];
  assign bus.wr_addr_a = wb_pipe_q[PIPE_LAT-1][5:3];
  assign bus.wr_addr_b = wb_pipe_q[PIPE_LAT-1][2:0];

endmodule
